uart_tx_arb: RTL and testbench

Round-robin arbiter and byte sequencer that lets NUM_REQ independent requesters share a single `uart_tx` serializer. Each requester offers a packet of bytes over a valid/ready stream. The owner keeps the transmitter until its `last` byte has finished shifting out, or until it stalls longer than the hold limit. The block sits between peripheral masters (debug console, bootloader, status reporter) and the `send`/`dout`/`busy`/`done` port of `uart_tx`.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_arb_if.sv | 25 ++
 rtl/uart_tx_arb_rr_pick.sv | 37 +++
 rtl/uart_tx_arb.sv | 142 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART-side arbiters and controllers.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    NEXT = 2'd3
  } uart_arb_state_t;

  localparam int BYTE_W = 8;

  // Increment an index with wrap back to zero at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side byte stream bundle: one valid/ready/last lane plus one byte per requester.
interface uart_tx_arb_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  // Out-of-range pointers (only possible for non-power-of-two N) fold to zero.
  function automatic logic [W-1:0] rot_idx(input logic [W-1:0] p, input int k);
    int j;
    j = int'(p) + k;
    if (j >= N) j = j - N;
    if (j >= N) j = 0;
    return W'(j);
  endfunction

  // Scan from the farthest offset down so the nearest valid request wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[rot_idx(ptr, k)]) begin
        gnt                = '0;
        gnt[rot_idx(ptr, k)] = 1'b1;
        idx                = rot_idx(ptr, k);
        any                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets several packet requesters share one uart_tx serializer,
// locking the transmitter to the owner until its last byte finishes or it stalls too long.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_arb_if.slave        req_if,
  output logic [NUM_REQ-1:0]  grant,
  output logic                tx_send,
  output logic [BYTE_W-1:0]   tx_dout,
  input  logic                tx_busy,
  input  logic                tx_done,
  output logic                idle
);

  localparam int IDX_W    = $clog2(NUM_REQ);
  localparam int HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int HOLD_LIM = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

  uart_arb_state_t     state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic                last_q, last_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic [IDX_W-1:0]    owner_nxt;
  logic [NUM_REQ-1:0]  ready_c;
  logic                send_c;
  logic [BYTE_W-1:0]   req_bytes [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign req_bytes[gi] = req_if.req_data[gi*BYTE_W +: BYTE_W];
      assign grant[gi]     = (state_q != IDLE) && (owner_q == IDX_W'(gi));
    end
  endgenerate

  rr_pick #(
    .N (NUM_REQ),
    .W (IDX_W)
  ) u_pick (
    .req (req_if.req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign owner_nxt = IDX_W'(wrap_inc(int'(owner_q), NUM_REQ));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    byte_d     = byte_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    ready_c    = '0;
    send_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          ready_c = pick_gnt;
          byte_d  = req_bytes[pick_idx];
          last_d  = req_if.req_last[pick_idx];
          owner_d = pick_idx;
          state_d = SEND;
        end
      end
      SEND: begin
        // Never pulse send into a transmitter that is still shifting.
        if (!tx_busy) begin
          send_c  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (last_q) begin
            ptr_d   = owner_nxt;
            state_d = IDLE;
          end else begin
            hold_cnt_d = '0;
            state_d    = NEXT;
          end
        end
      end
      NEXT: begin
        if (req_if.req_valid[owner_q]) begin
          ready_c[owner_q] = 1'b1;
          byte_d           = req_bytes[owner_q];
          last_d           = req_if.req_last[owner_q];
          state_d          = SEND;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          // Owner stalled too long mid-packet: drop the lock and let others in.
          if ((HOLD_CYCLES != 0) && (hold_cnt_q == HOLD_W'(HOLD_LIM))) begin
            ptr_d   = owner_nxt;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      byte_q     <= byte_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Ready is combinational, so mask it while reset is held to keep outputs quiet.
  assign req_if.req_ready = rst_n ? ready_c : '0;
  assign tx_send          = send_c;
  assign tx_dout          = byte_q;
  assign idle             = (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb with a behavioural uart_tx (4 clocks per bit).
module tb_uart_tx_arb;

  localparam int NR = 4;
  localparam int HC = 8;
  localparam int TO = 3000;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;
    bit         from_done;
  } item_t;

  typedef struct {
    int         owner;
    logic [7:0] data;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] grant;
  logic          tx_send;
  logic [7:0]    tx_dout;
  logic          tx_busy;
  logic          tx_done;
  logic          idle;
  logic          model_busy;
  logic          busy_force;
  logic          line;

  item_t rq [NR][$];
  exp_t  sb [$];
  int    total = 0;
  int    bad   = 0;
  int    sent  = 0;

  assign tx_busy = model_busy | busy_force;

  uart_tx_arb_if #(.NUM_REQ(NR)) req_if ();

  uart_tx_arb #(
    .NUM_REQ     (NR),
    .HOLD_CYCLES (HC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_if  (req_if.slave),
    .grant   (grant),
    .tx_send (tx_send),
    .tx_dout (tx_dout),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .idle    (idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  function automatic void push(input int r, input logic [7:0] d, input logic l,
                               input int gap, input bit fd);
    item_t it;
    it.data      = d;
    it.last      = l;
    it.gap       = gap;
    it.from_done = fd;
    rq[r].push_back(it);
  endfunction

  function automatic void expect_tx(input int o, input logic [7:0] d);
    exp_t e;
    e.owner = o;
    e.data  = d;
    sb.push_back(e);
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++)
      if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Requester driver: presents queued items, pops on a sampled valid&ready handshake.
  initial begin
    logic [NR-1:0] acc;
    logic          dn;
    int            wait_left [NR];
    bit            armed     [NR];
    req_if.req_valid = '0;
    req_if.req_data  = '0;
    req_if.req_last  = '0;
    for (int i = 0; i < NR; i++) begin
      wait_left[i] = 0;
      armed[i]     = 1'b0;
    end
    forever begin
      @(negedge clk);
      acc = req_if.req_valid & req_if.req_ready;
      dn  = tx_done;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i] && rq[i].size() > 0) begin
          void'(rq[i].pop_front());
          armed[i] = 1'b0;
        end
        if (rq[i].size() == 0) begin
          armed[i]            = 1'b0;
          req_if.req_valid[i] = 1'b0;
          req_if.req_last[i]  = 1'b0;
        end else begin
          if (!armed[i] && (!rq[i][0].from_done || dn)) begin
            armed[i]     = 1'b1;
            wait_left[i] = rq[i][0].gap;
          end
          if (armed[i] && wait_left[i] == 0) begin
            req_if.req_valid[i]         = 1'b1;
            req_if.req_data[i*8 +: 8]   = rq[i][0].data;
            req_if.req_last[i]          = rq[i][0].last;
          end else begin
            req_if.req_valid[i] = 1'b0;
            if (armed[i]) wait_left[i]--;
          end
        end
      end
    end
  end

  // Behavioural serializer: start bit, 8 data bits LSB first, stop bit, 4 clocks each.
  initial begin
    logic       s;
    logic [7:0] d;
    logic [7:0] cur;
    logic [9:0] frame;
    int         cyc;
    bit         dout_ok;
    model_busy = 1'b0;
    tx_done    = 1'b0;
    line       = 1'b1;
    cur        = '0;
    frame      = '1;
    cyc        = 0;
    dout_ok    = 1'b1;
    forever begin
      @(negedge clk);
      s = tx_send;
      d = tx_dout;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        model_busy = 1'b0;
        tx_done    = 1'b0;
        line       = 1'b1;
      end else begin
        tx_done = 1'b0;
        if (model_busy) begin
          if (tx_dout !== cur) dout_ok = 1'b0;
          cyc++;
          if (cyc == 40) begin
            model_busy = 1'b0;
            tx_done    = 1'b1;
            line       = 1'b1;
            check("dout_stable", {31'd0, dout_ok}, 32'd1);
          end else begin
            line = frame[cyc/4];
          end
        end else if (s) begin
          model_busy = 1'b1;
          cur        = d;
          frame      = {1'b1, d, 1'b0};
          cyc        = 0;
          line       = frame[0];
          dout_ok    = 1'b1;
        end
      end
    end
  end

  // Monitor: every send pulse pops the next expected (owner, byte) pair.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_send === 1'b1) begin
        sent++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_send actual=grant %0h byte %02h required=no send", grant, tx_dout);
        end else begin
          e = sb.pop_front();
          $display("tx owner=%0d byte=%02h grant=%b", e.owner, tx_dout, grant);
          check("send_grant", 32'(grant), 32'(1) << e.owner);
          check("send_dout", 32'(tx_dout), 32'(e.data));
          check("send_not_busy", 32'(tx_busy), 32'd0);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) rq[i].delete();
    sb.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (n < TO && !(sb.size() == 0 && idle === 1'b1 && !model_busy && all_empty())) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= TO) begin
      bad++;
      $display("FAIL %s_drain actual=timeout pending=%0d required=drained", nm, sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (tx_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL %s_done actual=timeout required=tx_done", nm);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=still running required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         k;
    int         base;
    logic [9:0] rx;
    rst_n      = 1'b0;
    busy_force = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ready", 32'(req_if.req_ready), 32'd0);
    check("rst_send", 32'(tx_send), 32'd0);
    check("rst_dout", 32'(tx_dout), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single byte 0x55 from requester 0.
    push(0, 8'h55, 1'b1, 0, 1'b0);
    expect_tx(0, 8'h55);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_if.req_valid[0] !== 1'b1 && n < 5);
    check("t1_ready_same_cycle", 32'(req_if.req_ready), 32'h1);
    @(negedge clk);
    check("t1_send_next_cycle", 32'(tx_send), 32'd1);
    @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      rx[b] = line;
      repeat (3) @(negedge clk);
    end
    check("t1_line_frame", 32'(rx), 32'({1'b1, 8'h55, 1'b0}));
    wait_done("t1");
    @(negedge clk);
    check("t1_idle_after_done", 32'(idle), 32'd1);
    drain("t1");

    // Packet lock: requester 1 keeps the transmitter while requester 2 waits.
    do_reset();
    push(1, 8'hA0, 1'b0, 0, 1'b0);
    push(1, 8'hA1, 1'b0, 0, 1'b0);
    push(1, 8'hA2, 1'b1, 0, 1'b0);
    push(2, 8'hB2, 1'b1, 0, 1'b0);
    expect_tx(1, 8'hA0);
    expect_tx(1, 8'hA1);
    expect_tx(1, 8'hA2);
    expect_tx(2, 8'hB2);
    drain("t2");

    // Round robin with everyone valid: 0,1,2,3 then wrap to 0.
    do_reset();
    for (int r = 0; r < NR; r++) push(r, 8'(8'h30 + r), 1'b1, 0, 1'b0);
    for (int r = 0; r < NR; r++) push(r, 8'(8'h40 + r), 1'b1, 0, 1'b0);
    for (int r = 0; r < NR; r++) expect_tx(r, 8'(8'h30 + r));
    for (int r = 0; r < NR; r++) expect_tx(r, 8'(8'h40 + r));
    drain("t3");

    // Busy guard: no send while the transmitter reports busy, exactly one afterwards.
    do_reset();
    busy_force = 1'b1;
    push(2, 8'h5A, 1'b1, 0, 1'b0);
    expect_tx(2, 8'h5A);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      n += int'(tx_send);
    end
    check("t4_no_send_while_busy", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    busy_force = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      n += int'(tx_send);
    end
    check("t4_single_send", 32'(n), 32'd1);
    drain("t4");

    // Hold revoke: owner 0 stalls 8 NEXT cycles, grant moves to requester 3.
    do_reset();
    push(0, 8'h11, 1'b0, 0, 1'b0);
    push(3, 8'h33, 1'b1, 0, 1'b0);
    expect_tx(0, 8'h11);
    expect_tx(3, 8'h33);
    wait_done("t5");
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (grant === 4'b0001 && k < 30);
    check("t5_revoke_cycle", 32'(k), 32'd9);
    check("t5_idle_on_revoke", 32'(idle), 32'd1);
    @(negedge clk);
    check("t5_grant_moves", 32'(grant), 32'h8);
    drain("t5");

    // Variant: valid returns in the 8th NEXT cycle, byte accepted and lock kept.
    do_reset();
    push(0, 8'h11, 1'b0, 0, 1'b0);
    push(0, 8'h12, 1'b1, HC - 1, 1'b1);
    push(3, 8'h33, 1'b1, 0, 1'b0);
    expect_tx(0, 8'h11);
    expect_tx(0, 8'h12);
    expect_tx(3, 8'h33);
    drain("t5b");

    // Async reset during byte 2 of a packet; arbitration restarts at ptr 0.
    do_reset();
    push(2, 8'h22, 1'b1, 0, 1'b0);
    expect_tx(2, 8'h22);
    drain("t6a");
    base = sent;
    push(1, 8'h61, 1'b0, 0, 1'b0);
    push(1, 8'h62, 1'b0, 0, 1'b0);
    push(1, 8'h63, 1'b1, 0, 1'b0);
    expect_tx(1, 8'h61);
    expect_tx(1, 8'h62);
    expect_tx(1, 8'h63);
    n = 0;
    while (sent < base + 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_byte2", 32'(sent - base), 32'd2);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_ready", 32'(req_if.req_ready), 32'd0);
    check("t6_rst_send", 32'(tx_send), 32'd0);
    check("t6_rst_dout", 32'(tx_dout), 32'd0);
    check("t6_rst_idle", 32'(idle), 32'd1);
    for (int i = 0; i < NR; i++) rq[i].delete();
    sb.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(3, 8'h73, 1'b1, 0, 1'b0);
    push(1, 8'h71, 1'b1, 0, 1'b0);
    expect_tx(1, 8'h71);
    expect_tx(3, 8'h73);
    drain("t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
